// File: rtl/i2s_tx_if.sv
// Sample stream handshake between the tone generators and i2s_tx.
`timescale 1ns/1ps
interface i2s_tx_if #(
    parameter int unsigned width_p = 12
);
    logic [width_p-1:0] data;
    logic               valid;
    logic               ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/i2s_tx.sv
// I2S transmitter: one-entry holding register feeding a mono-duplicated I2S frame.
// Optional I2S_TX_MUTE_ON_UNDERRUN_EN: on underrun send silence instead of repeating the last sample.
`timescale 1ns/1ps
module i2s_tx #(
    parameter int unsigned width_p      = 12,
    parameter int unsigned slot_width_p = 16,
    parameter int unsigned bclk_div_p   = 4
) (
    input  logic      clk_i,
    input  logic      reset_ni,
    i2s_tx_if.slave   in_if,
    output logic      bclk_o,
    output logic      lrclk_o,
    output logic      sdata_o,
    output logic      underrun_o
);
    localparam int unsigned FRAME_BITS = 2 * slot_width_p;
    localparam int unsigned IDX_W      = $clog2(FRAME_BITS);
    localparam int unsigned DIV_W      = (bclk_div_p > 1) ? $clog2(bclk_div_p) : 1;
    localparam int unsigned SEL_W      = (width_p > 1) ? $clog2(width_p) : 1;

    logic [DIV_W-1:0]   div_q;
    logic [IDX_W-1:0]   idx_q, idx_nxt;
    logic [width_p-1:0] hold_q, frame_q, frame_nxt;
    logic               hold_full_q;
    logic               bclk_q, lrclk_q, sdata_q, underrun_q;
    logic               div_wrap, fe, frame_start, accept;
    logic               lrclk_nxt, sdata_nxt, underrun_nxt;
    logic [SEL_W-1:0]   sel;
    int unsigned        pos, idx_u;

    assign in_if.ready = !hold_full_q;
    assign accept      = in_if.valid && !hold_full_q;

    assign div_wrap    = (div_q == DIV_W'(bclk_div_p - 1));
    assign fe          = div_wrap && bclk_q;
    assign frame_start = fe && (idx_q == IDX_W'(FRAME_BITS - 1));
    assign idx_nxt     = (idx_q == IDX_W'(FRAME_BITS - 1)) ? '0 : idx_q + 1'b1;

    // Outputs are computed for the bit index being entered, so they change
    // only on the BCLK falling edge together with the index.
    always_comb begin
        frame_nxt    = frame_q;
        underrun_nxt = 1'b0;
        if (frame_start) begin
            if (hold_full_q) begin
                frame_nxt = hold_q;
            end else begin
                underrun_nxt = 1'b1;
`ifdef I2S_TX_MUTE_ON_UNDERRUN_EN
                frame_nxt = '0;
`else
                frame_nxt = frame_q;
`endif
            end
        end
        idx_u     = 32'(idx_nxt);
        pos       = idx_u % slot_width_p;
        sel       = SEL_W'(width_p - 1 - pos);
        sdata_nxt = (pos < width_p) ? frame_nxt[sel] : 1'b0;
        lrclk_nxt = (idx_u >= slot_width_p - 1) && (idx_u <= FRAME_BITS - 2);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            div_q       <= '0;
            bclk_q      <= 1'b0;
            idx_q       <= IDX_W'(FRAME_BITS - 1);
            frame_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            lrclk_q     <= 1'b0;
            sdata_q     <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            div_q      <= div_wrap ? '0 : div_q + 1'b1;
            underrun_q <= underrun_nxt;
            if (div_wrap) begin
                bclk_q <= ~bclk_q;
            end
            if (fe) begin
                idx_q   <= idx_nxt;
                frame_q <= frame_nxt;
                lrclk_q <= lrclk_nxt;
                sdata_q <= sdata_nxt;
            end
            // Drain and accept never coincide: accept needs the register empty.
            if (frame_start && hold_full_q) begin
                hold_full_q <= 1'b0;
            end else if (accept) begin
                hold_q      <= in_if.data;
                hold_full_q <= 1'b1;
            end
        end
    end

    assign bclk_o     = bclk_q;
    assign lrclk_o    = lrclk_q;
    assign sdata_o    = sdata_q;
    assign underrun_o = underrun_q;
endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: per-cycle comparison against a frame-level model plus directed literal frames.
`timescale 1ns/1ps
module tb_i2s_tx;
    localparam int unsigned W = 12;
    localparam int unsigned S = 16;
    localparam int unsigned D = 4;

    logic clk_i    = 1'b0;
    logic reset_ni = 1'b0;
    logic bclk_o, lrclk_o, sdata_o, underrun_o;

    i2s_tx_if #(.width_p(W)) bus ();

    i2s_tx #(.width_p(W), .slot_width_p(S), .bclk_div_p(D)) dut (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
        .in_if      (bus),
        .bclk_o     (bclk_o),
        .lrclk_o    (lrclk_o),
        .sdata_o    (sdata_o),
        .underrun_o (underrun_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: time n = clk edges since reset release; FE k happens at n = 2*D*k,
    // bit index after FE k is (k-1) mod 2S, each index 0 starts a new frame.
    int             n        = 0;
    logic           m_full   = 1'b0;
    logic [W-1:0]   m_hold   = '0;
    logic [W-1:0]   m_frame  = '0;
    logic           m_under  = 1'b0;
    int             m_fcount = 0;
    int             under_cnt = 0;

    always @(posedge clk_i or negedge reset_ni) begin
        logic was_full;
        logic fs;
        if (!reset_ni) begin
            n = 0; m_full = 1'b0; m_hold = '0; m_frame = '0; m_under = 1'b0;
        end else begin
            n++;
            was_full = m_full;
            m_under  = 1'b0;
            fs = (n % (2 * D) == 0) && (((n / (2 * D)) - 1) % (2 * S) == 0);
            if (fs) begin
                m_fcount++;
                if (was_full) begin
                    m_frame = m_hold;
                    m_full  = 1'b0;
                end else begin
                    m_under = 1'b1;
`ifdef I2S_TX_MUTE_ON_UNDERRUN_EN
                    m_frame = '0;
`endif
                end
            end
            if (bus.valid && !was_full) begin
                m_hold = bus.data;
                m_full = 1'b1;
            end
        end
    end

    always @(negedge clk_i) begin
        int k, b, j;
        logic e_bclk, e_lr, e_sd;
        k      = n / (2 * D);
        e_bclk = ((n / D) % 2) == 1;
        e_lr   = 1'b0;
        e_sd   = 1'b0;
        if (k > 0) begin
            b    = (k - 1) % (2 * S);
            j    = b % S;
            e_lr = (b >= S - 1) && (b <= 2 * S - 2);
            e_sd = (j < W) ? m_frame[W - 1 - j] : 1'b0;
        end
        chk("bclk",     32'(bclk_o),     32'(e_bclk));
        chk("lrclk",    32'(lrclk_o),    32'(e_lr));
        chk("sdata",    32'(sdata_o),    32'(e_sd));
        chk("underrun", 32'(underrun_o), 32'(m_under));
        chk("ready",    32'(bus.ready),  32'(!m_full));
        if (underrun_o) under_cnt++;
    end

    task automatic push(input logic [W-1:0] v);
        logic ok;
        ok = 1'b0;
        @(negedge clk_i);
        bus.valid = 1'b1;
        bus.data  = v;
        for (int i = 0; i < 600; i++) begin
            if (bus.ready) begin ok = 1'b1; break; end
            @(negedge clk_i);
        end
        @(negedge clk_i);
        bus.valid = 1'b0;
        chk("push_accept", 32'(ok), 32'd1);
    endtask

    task automatic wait_frame();
        int s;
        s = m_fcount;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk_i);
            if (m_fcount != s) break;
        end
        chk("frame_wait", 32'(m_fcount != s), 32'd1);
    endtask

    // Samples SDATA/LRCLK on BCLK rising edges, as the DAC does.
    task automatic capture(input string name, output logic [31:0] sd, output logic [31:0] lr);
        logic prev;
        int   got;
        sd = '0; lr = '0; got = 0;
        prev = bclk_o;
        for (int i = 0; i < 400 && got < 32; i++) begin
            @(negedge clk_i);
            if (!prev && bclk_o) begin
                sd = {sd[30:0], sdata_o};
                lr = {lr[30:0], lrclk_o};
                got++;
            end
            prev = bclk_o;
        end
        chk({name, "_bits"}, 32'(got), 32'd32);
    endtask

    task automatic wait_rises(input int cnt);
        logic prev;
        int   got;
        got = 0;
        prev = bclk_o;
        for (int i = 0; i < 400 && got < cnt; i++) begin
            @(negedge clk_i);
            if (!prev && bclk_o) got++;
            prev = bclk_o;
        end
        chk("rise_wait", 32'(got), 32'(cnt));
    endtask

    initial begin
        logic [31:0] sd, lr, exp_f1;
        int cnt, u0;
        bus.valid = 1'b0;
        bus.data  = '0;

        repeat (5) @(negedge clk_i);
        chk("rst_bclk",  32'(bclk_o),    32'd0);
        chk("rst_sdata", 32'(sdata_o),   32'd0);
        chk("rst_ready", 32'(bus.ready), 32'd1);
        reset_ni = 1'b1;

        cnt = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk_i); #1;
            if (bclk_o) begin cnt = i; break; end
        end
        chk("first_bclk_rise", 32'(cnt), 32'd4);

        push(12'hA5C);
        wait_frame();
        capture("f0", sd, lr);
        chk("f0_sdata", sd, 32'hA5C0_A5C0);
        chk("f0_lrclk", lr, 32'h0001_FFFE);

        u0 = under_cnt;
        wait_frame();
        capture("f1", sd, lr);
`ifdef I2S_TX_MUTE_ON_UNDERRUN_EN
        exp_f1 = 32'h0000_0000;
`else
        exp_f1 = 32'hA5C0_A5C0;
`endif
        chk("f1_sdata", sd, exp_f1);
        chk("f1_underrun_pulses", 32'(under_cnt - u0), 32'd1);

        push(12'h123);
        push(12'h456);
        capture("f2", sd, lr);
        chk("f2_sdata", sd, 32'h1230_1230);
        wait_frame();
        capture("f3", sd, lr);
        chk("f3_sdata", sd, 32'h4560_4560);

        push(12'h800);
        wait_frame();
        capture("f4", sd, lr);
        chk("f4_sdata", sd, 32'h8000_8000);
        chk("f4_lrclk", lr, 32'h0001_FFFE);

        push(12'h7FF);
        wait_frame();
        push(12'h001);
        wait_rises(11);
        #1 reset_ni = 1'b0;
        #1;
        chk("async_bclk",     32'(bclk_o),     32'd0);
        chk("async_lrclk",    32'(lrclk_o),    32'd0);
        chk("async_sdata",    32'(sdata_o),    32'd0);
        chk("async_underrun", 32'(underrun_o), 32'd0);
        chk("async_ready",    32'(bus.ready),  32'd1);
        repeat (5) @(negedge clk_i);
        reset_ni = 1'b1;
        u0 = under_cnt;
        wait_frame();
        capture("f_rst", sd, lr);
        chk("f_rst_sdata", sd, 32'h0000_0000);
        chk("f_rst_underrun_pulses", 32'(under_cnt - u0), 32'd1);

        for (int chunk = 0; chunk < 9; chunk++) begin
            int pct;
            pct = (chunk % 3 == 0) ? 0 : ((chunk % 3 == 1) ? 1 : 60);
            for (int c = 0; c < 512; c++) begin
                @(negedge clk_i);
                bus.valid = ($urandom_range(0, 99) < pct);
                bus.data  = W'($urandom);
            end
        end
        @(negedge clk_i);
        bus.valid = 1'b0;
        repeat (4) @(negedge clk_i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
